ddr3_port_arbiter: RTL and testbench

Shares one MIG user port (command, write FIFO and read FIFO) between two requesters: a read requester (LCD framebuffer prefetch) and a write requester (framebuffer pixel writer). The block sits between the requesters and the MIG. It serialises bursts, moves write data into the MIG write FIFO ahead of the write command, and returns read data to the read requester. Reads have priority, and a bounded starvation counter guarantees write progress.

---
 rtl/ddr3_pkg.sv | 19 +
 rtl/ddr3_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 MIG user-port arbiter: MIG instruction codes,
// port widths and the one-hot arbiter state encoding.
package ddr3_pkg;

    localparam int MIG_ADDR_W = 30;
    localparam int MIG_BL_W   = 6;

    localparam logic [2:0] MIG_INSTR_WR = 3'b000;
    localparam logic [2:0] MIG_INSTR_RD = 3'b001;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_RD_CMD   = 5'b00010,
        ST_RD_DRAIN = 5'b00100,
        ST_WR_FILL  = 5'b01000,
        ST_WR_CMD   = 5'b10000
    } state_t;

endpackage

// File: rtl/ddr3_port_arbiter.sv
// Shares one MIG user port between a read requester and a write requester.
// Reads win by default; a saturating starvation counter forces a write through.
//
// state       | meaning
// ST_IDLE     | waiting for calibration and a request; arbitration happens here
// ST_RD_CMD   | issuing the read command to the MIG command FIFO
// ST_RD_DRAIN | popping bl+1 words from the MIG read FIFO
// ST_WR_FILL  | pushing bl+1 words into the MIG write FIFO
// ST_WR_CMD   | issuing the write command once all data is in the FIFO
module ddr3_port_arbiter
    import ddr3_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mig_ready_i,
    output logic                  mig_cmd_en,
    output logic [2:0]            mig_cmd_instr,
    output logic [MIG_BL_W-1:0]   mig_cmd_bl,
    output logic [MIG_ADDR_W-1:0] mig_cmd_byte_addr,
    input  logic                  mig_cmd_full,
    output logic                  mig_wr_en,
    output logic [31:0]           mig_wr_data,
    output logic [3:0]            mig_wr_mask,
    input  logic                  mig_wr_full,
    output logic                  mig_rd_en,
    input  logic [31:0]           mig_rd_data,
    input  logic                  mig_rd_empty,
    input  logic                  rd_req_i,
    input  logic [MIG_ADDR_W-1:0] rd_addr_i,
    input  logic [MIG_BL_W-1:0]   rd_bl_i,
    output logic                  rd_gnt_o,
    output logic                  rd_valid_o,
    output logic [31:0]           rd_data_o,
    output logic                  rd_done_o,
    input  logic                  wr_req_i,
    input  logic [MIG_ADDR_W-1:0] wr_addr_i,
    input  logic [MIG_BL_W-1:0]   wr_bl_i,
    output logic                  wr_gnt_o,
    input  logic [31:0]           wr_data_i,
    output logic                  wr_pop_o,
    output logic                  wr_done_o,
    output logic                  busy_o
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [MIG_ADDR_W-1:0] addr_q, addr_d;
    logic [MIG_BL_W-1:0]   bl_q, bl_d;
    logic [MIG_BL_W-1:0]   beat_q, beat_d;
    logic [SC_W-1:0]       starve_q, starve_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_done_q, rd_done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            bl_q       <= '0;
            beat_q     <= '0;
            starve_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bl_q       <= bl_d;
            beat_q     <= beat_d;
            starve_q   <= starve_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_done_q  <= rd_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        bl_d          = bl_q;
        beat_d        = beat_q;
        starve_d      = starve_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        rd_done_d     = 1'b0;
        mig_cmd_en    = 1'b0;
        mig_cmd_instr = MIG_INSTR_WR;
        mig_wr_en     = 1'b0;
        mig_rd_en     = 1'b0;
        wr_pop_o      = 1'b0;
        rd_gnt_o      = 1'b0;
        wr_gnt_o      = 1'b0;
        wr_done_o     = 1'b0;

        // Strobes are held off while rst is high so a mid-burst reset moves no data.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mig_ready_i) begin
                        if (rd_req_i && (!wr_req_i || (starve_q < STARVE_MAX))) begin
                            rd_gnt_o = 1'b1;
                            addr_d   = rd_addr_i;
                            bl_d     = rd_bl_i;
                            beat_d   = rd_bl_i;
                            state_d  = ST_RD_CMD;
                        end else if (wr_req_i) begin
                            wr_gnt_o = 1'b1;
                            addr_d   = wr_addr_i;
                            bl_d     = wr_bl_i;
                            beat_d   = wr_bl_i;
                            state_d  = ST_WR_FILL;
                        end
                    end
                end
                ST_RD_CMD: begin
                    mig_cmd_instr = MIG_INSTR_RD;
                    if (!mig_cmd_full) begin
                        mig_cmd_en = 1'b1;
                        state_d    = ST_RD_DRAIN;
                        if (!wr_req_i)
                            starve_d = '0;
                        else if (starve_q != STARVE_MAX)
                            starve_d = starve_q + 1'b1;
                    end
                end
                ST_RD_DRAIN: begin
                    mig_rd_en = !mig_rd_empty;
                    if (!mig_rd_empty) begin
                        rd_data_d  = mig_rd_data;
                        rd_valid_d = 1'b1;
                        if (beat_q == '0) begin
                            rd_done_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            beat_d = beat_q - 1'b1;
                        end
                    end
                end
                ST_WR_FILL: begin
                    mig_wr_en = !mig_wr_full;
                    wr_pop_o  = !mig_wr_full;
                    if (!mig_wr_full) begin
                        if (beat_q == '0)
                            state_d = ST_WR_CMD;
                        else
                            beat_d = beat_q - 1'b1;
                    end
                end
                ST_WR_CMD: begin
                    if (!mig_cmd_full) begin
                        mig_cmd_en = 1'b1;
                        wr_done_o  = 1'b1;
                        starve_d   = '0;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign mig_wr_data       = wr_data_i;
    assign mig_wr_mask       = 4'b0000;
    assign mig_cmd_bl        = bl_q;
    assign mig_cmd_byte_addr = addr_q;
    assign rd_valid_o        = rd_valid_q;
    assign rd_data_o         = rd_data_q;
    assign rd_done_o         = rd_done_q;
    assign busy_o            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Self-checking bench for ddr3_port_arbiter: arbitration table, directed
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_ddr3_port_arbiter;
    import ddr3_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mig_ready_i, mig_cmd_en, mig_cmd_full, mig_wr_en, mig_wr_full;
    logic [2:0]  mig_cmd_instr;
    logic [5:0]  mig_cmd_bl, rd_bl_i, wr_bl_i;
    logic [29:0] mig_cmd_byte_addr, rd_addr_i, wr_addr_i;
    logic [31:0] mig_wr_data, mig_rd_data, rd_data_o, wr_data_i;
    logic [3:0]  mig_wr_mask;
    logic        mig_rd_en, mig_rd_empty, rd_req_i, rd_gnt_o, rd_valid_o, rd_done_o;
    logic        wr_req_i, wr_gnt_o, wr_pop_o, wr_done_o, busy_o;

    ddr3_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .mig_ready_i(mig_ready_i),
        .mig_cmd_en(mig_cmd_en), .mig_cmd_instr(mig_cmd_instr), .mig_cmd_bl(mig_cmd_bl),
        .mig_cmd_byte_addr(mig_cmd_byte_addr), .mig_cmd_full(mig_cmd_full),
        .mig_wr_en(mig_wr_en), .mig_wr_data(mig_wr_data), .mig_wr_mask(mig_wr_mask),
        .mig_wr_full(mig_wr_full), .mig_rd_en(mig_rd_en), .mig_rd_data(mig_rd_data),
        .mig_rd_empty(mig_rd_empty),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_bl_i(rd_bl_i), .rd_gnt_o(rd_gnt_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_done_o(rd_done_o),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_bl_i(wr_bl_i), .wr_gnt_o(wr_gnt_o),
        .wr_data_i(wr_data_i), .wr_pop_o(wr_pop_o), .wr_done_o(wr_done_o), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [2:0]  instr;
        logic [29:0] addr;
        logic [5:0]  bl;
        logic        done;
    } cmd_t;

    // event logs, cleared on every reset
    cmd_t        cmd_log[$];
    logic [31:0] push_log[$];
    logic [32:0] rdv_log[$];
    byte         gnt_log[$];
    int          gnt_cyc[$], push_cyc[$], pop_cyc[$], rdv_cyc[$];
    int          wr_done_cnt;

    // MIG and requester environment
    logic [31:0] rd_fifo[$], wr_src[$], exp_rd[$], exp_wr[$];
    int          cyc, rd_hold, rd_hold_on_gnt, cmd_full_n, cmd_full_on_gnt, wr_full_n, wr_full_trig;
    bit          hold_req, rand_on, rand_stop, rd_force;
    logic [31:0] rd_word, wr_word;
    bit          s_rd_pop, s_wr_pop, s_rd_gnt, s_wr_gnt, s_busy, s_cmd_en;

    // transaction-level reference state for the randomized run
    int          m_starve, p_beats, rd_dly, wr_dly, n_grants;
    bit          m_busy, p_is_rd;
    logic [29:0] p_addr;
    logic [5:0]  p_bl;

    function automatic logic [5:0] pick_bl();
        case ($urandom_range(0, 5))
            0:       return 6'd0;
            1:       return 6'd63;
            default: return 6'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic score();
        bit er, ew;
        logic [31:0] w;
        check("busy", busy_o, m_busy);
        if (!m_busy) begin
            er = rd_req_i && (!wr_req_i || m_starve < LIMIT);
            ew = wr_req_i && !er;
            check("rd_gnt", rd_gnt_o, er);
            check("wr_gnt", wr_gnt_o, ew);
            if (er || ew) begin
                p_is_rd = er;
                p_addr  = er ? rd_addr_i : wr_addr_i;
                p_bl    = er ? rd_bl_i : wr_bl_i;
                p_beats = 0;
                m_busy  = 1'b1;
                n_grants++;
            end
        end else begin
            check("gnt_while_busy", rd_gnt_o | wr_gnt_o, 0);
            if (mig_cmd_en) begin
                check("cmd_instr", mig_cmd_instr, p_is_rd ? 3'b001 : 3'b000);
                check("cmd_addr", mig_cmd_byte_addr, p_addr);
                check("cmd_bl", mig_cmd_bl, p_bl);
                if (p_is_rd) begin
                    m_starve = wr_req_i ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
                end else begin
                    check("wr_beats_before_cmd", p_beats, int'(p_bl) + 1);
                    check("wr_done_with_cmd", wr_done_o, 1);
                    m_starve = 0;
                    m_busy   = 1'b0;
                end
            end
            if (mig_wr_en) begin
                check("wr_push_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    check("wr_push_data", mig_wr_data, w);
                end
                p_beats++;
            end
            if (mig_rd_en) begin
                p_beats++;
                if (p_beats == int'(p_bl) + 1) m_busy = 1'b0;
            end
        end
        if (rd_valid_o) begin
            check("rd_valid_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) begin
                w = exp_rd.pop_front();
                check("rd_data", rd_data_o, w);
                check("rd_done", rd_done_o, exp_rd.size() == 0);
            end
        end
    endtask

    task automatic monitor();
        s_rd_pop = mig_rd_en;
        s_wr_pop = wr_pop_o;
        s_rd_gnt = rd_gnt_o;
        s_wr_gnt = wr_gnt_o;
        s_busy   = busy_o;
        s_cmd_en = mig_cmd_en;
        if (rd_gnt_o) begin gnt_log.push_back("R"); gnt_cyc.push_back(cyc); end
        if (wr_gnt_o) begin gnt_log.push_back("W"); gnt_cyc.push_back(cyc); end
        if (mig_cmd_en) cmd_log.push_back('{cyc, mig_cmd_instr, mig_cmd_byte_addr, mig_cmd_bl, wr_done_o});
        if (mig_wr_en) begin push_log.push_back(mig_wr_data); push_cyc.push_back(cyc); end
        if (mig_rd_en) pop_cyc.push_back(cyc);
        if (rd_valid_o) begin rdv_log.push_back({rd_done_o, rd_data_o}); rdv_cyc.push_back(cyc); end
        if (wr_done_o) wr_done_cnt++;
        if (rand_on && !rst) score();
    endtask

    task automatic env_update();
        logic [31:0] w;
        cyc++;
        if (s_rd_pop && rd_fifo.size() > 0) void'(rd_fifo.pop_front());
        if (s_wr_pop && wr_src.size() > 0) void'(wr_src.pop_front());
        if (s_rd_gnt) begin
            for (int i = 0; i <= int'(rd_bl_i); i++) begin
                w = rand_on ? $urandom : rd_word;
                rd_word++;
                rd_fifo.push_back(w);
                exp_rd.push_back(w);
            end
            rd_hold    = rd_hold_on_gnt;
            cmd_full_n = cmd_full_on_gnt;
            if (!hold_req) rd_req_i = 1'b0;
        end
        if (s_wr_gnt) begin
            for (int i = 0; i <= int'(wr_bl_i); i++) begin
                w = rand_on ? $urandom : wr_word;
                wr_word++;
                wr_src.push_back(w);
                exp_wr.push_back(w);
            end
            if (!hold_req) wr_req_i = 1'b0;
        end
        if (wr_full_trig > 0 && push_log.size() == wr_full_trig) begin
            wr_full_n    = 2;
            wr_full_trig = 0;
        end
        if (rand_on) begin
            mig_cmd_full = ($urandom_range(0, 3) == 0);
            mig_wr_full  = ($urandom_range(0, 3) == 0);
            rd_force     = ($urandom_range(0, 2) == 0);
            if (!rd_req_i && !rand_stop) begin
                if (rd_dly > 0) rd_dly--;
                else begin
                    rd_req_i = 1'b1; rd_addr_i = 30'($urandom); rd_bl_i = pick_bl();
                    rd_dly = $urandom_range(0, 4);
                end
            end
            if (!wr_req_i && !rand_stop) begin
                if (wr_dly > 0) wr_dly--;
                else begin
                    wr_req_i = 1'b1; wr_addr_i = 30'($urandom); wr_bl_i = pick_bl();
                    wr_dly = $urandom_range(0, 4);
                end
            end
        end else begin
            mig_cmd_full = (cmd_full_n > 0);
            if (cmd_full_n > 0) cmd_full_n--;
            mig_wr_full = (wr_full_n > 0);
            if (wr_full_n > 0) wr_full_n--;
            rd_force = (rd_hold > 0);
            if (rd_hold > 0) rd_hold--;
        end
        mig_rd_empty = rd_force || (rd_fifo.size() == 0);
        mig_rd_data  = (rd_fifo.size() > 0) ? rd_fifo[0] : 32'h0;
        wr_data_i    = (wr_src.size() > 0) ? wr_src[0] : 32'h0;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        env_update();
    endtask

    task automatic do_reset();
        rst = 1'b1; mig_ready_i = 1'b0;
        rd_req_i = 1'b0; rd_addr_i = '0; rd_bl_i = '0;
        wr_req_i = 1'b0; wr_addr_i = '0; wr_bl_i = '0;
        rd_fifo.delete(); wr_src.delete(); exp_rd.delete(); exp_wr.delete();
        rd_hold = 0; rd_hold_on_gnt = 0; cmd_full_n = 0; cmd_full_on_gnt = 0;
        wr_full_n = 0; wr_full_trig = 0; hold_req = 0; rand_on = 0; rand_stop = 0;
        rd_word = 0; wr_word = 0; m_busy = 0; m_starve = 0; n_grants = 0;
        tick();
        tick();
        rst = 1'b0;
        cmd_log.delete(); push_log.delete(); rdv_log.delete(); gnt_log.delete();
        gnt_cyc.delete(); push_cyc.delete(); pop_cyc.delete(); rdv_cyc.delete();
        wr_done_cnt = 0;
    endtask

    typedef struct { bit ready; bit rd; bit wr; bit e_rg; bit e_wg; } arb_vec_t;
    arb_vec_t vecs[6];
    string    exp_seq;
    int       n, rc;

    initial begin
        vecs = '{'{1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
                 '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
                 '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
                 '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
                 '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
                 '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};
        cyc = 0;
        mig_cmd_full = 0; mig_wr_full = 0; mig_rd_empty = 1; mig_rd_data = 0; wr_data_i = 0;
        do_reset();

        // reset values, with both requests pending and calibration done
        rst = 1'b1; mig_ready_i = 1'b1; rd_req_i = 1'b1; wr_req_i = 1'b1;
        tick();
        @(negedge clk);
        check("rst_gnt", {rd_gnt_o, wr_gnt_o}, 0);
        check("rst_strobes", {mig_cmd_en, mig_wr_en, mig_rd_en, wr_pop_o, rd_valid_o, rd_done_o, wr_done_o}, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data_addr_bl", {rd_data_o, mig_cmd_byte_addr, mig_cmd_bl}, 0);
        check("wr_mask", mig_wr_mask, 0);
        @(posedge clk);
        #1;

        // arbitration table from a fresh reset (starvation counter 0)
        for (int i = 0; i < 6; i++) begin
            do_reset();
            mig_ready_i = vecs[i].ready; rd_req_i = vecs[i].rd; wr_req_i = vecs[i].wr;
            tick();
            check($sformatf("tbl%0d_rd_gnt", i), s_rd_gnt, vecs[i].e_rg);
            check($sformatf("tbl%0d_wr_gnt", i), s_wr_gnt, vecs[i].e_wg);
            check($sformatf("tbl%0d_busy0", i), s_busy, 0);
            tick();
            check($sformatf("tbl%0d_busy1", i), s_busy, vecs[i].e_rg | vecs[i].e_wg);
            check($sformatf("tbl%0d_cmd1", i), s_cmd_en, vecs[i].e_rg);
        end

        // read only: 8 beats after 5 empty cycles
        do_reset();
        mig_ready_i = 1; rd_req_i = 1; rd_addr_i = 30'h1000; rd_bl_i = 6'd7; rd_hold_on_gnt = 5;
        n = 0;
        while (rdv_log.size() < 8 && n < 200) begin tick(); n++; end
        check("rd_cmd_count", cmd_log.size(), 1);
        if (cmd_log.size() > 0) begin
            check("rd_cmd_instr", cmd_log[0].instr, 3'b001);
            check("rd_cmd_addr", cmd_log[0].addr, 30'h1000);
            check("rd_cmd_bl", cmd_log[0].bl, 7);
            check("rd_cmd_latency", cmd_log[0].cyc - gnt_cyc[0], 1);
        end
        check("rd_beats", rdv_log.size(), 8);
        for (int i = 0; i < rdv_log.size(); i++)
            check($sformatf("rd_beat%0d", i), rdv_log[i], {(i == 7), 32'(i)});
        if (pop_cyc.size() > 0 && rdv_cyc.size() > 0)
            check("rd_valid_latency", rdv_cyc[0] - pop_cyc[0], 1);

        // write only with 2 cycles of write-FIFO full mid-fill
        do_reset();
        mig_ready_i = 1; wr_req_i = 1; wr_addr_i = 30'h2000; wr_bl_i = 6'd3;
        wr_word = 32'hA0; wr_full_trig = 2;
        n = 0;
        while (wr_done_cnt < 1 && n < 200) begin tick(); n++; end
        check("wr_push_count", push_log.size(), 4);
        for (int i = 0; i < push_log.size(); i++)
            check($sformatf("wr_push%0d", i), push_log[i], 32'hA0 + 32'(i));
        check("wr_cmd_count", cmd_log.size(), 1);
        if (cmd_log.size() > 0 && push_cyc.size() > 0) begin
            check("wr_cmd_instr", cmd_log[0].instr, 3'b000);
            check("wr_cmd_addr", cmd_log[0].addr, 30'h2000);
            check("wr_cmd_after_push", cmd_log[0].cyc > push_cyc[push_cyc.size() - 1], 1);
            check("wr_done_with_cmd", cmd_log[0].done, 1);
        end
        check("wr_done_count", wr_done_cnt, 1);

        // write with no backpressure: command lands bl+2 cycles after grant
        do_reset();
        mig_ready_i = 1; wr_req_i = 1; wr_addr_i = 30'h3000; wr_bl_i = 6'd5;
        n = 0;
        while (wr_done_cnt < 1 && n < 100) begin tick(); n++; end
        check("wr_nobp_pushes", push_log.size(), 6);
        if (cmd_log.size() > 0 && gnt_cyc.size() > 0)
            check("wr_nobp_cmd_cycle", cmd_log[0].cyc - gnt_cyc[0], 7);

        // starvation: both requests held continuously
        do_reset();
        mig_ready_i = 1; hold_req = 1; rd_req_i = 1; wr_req_i = 1;
        rd_addr_i = 30'h40; wr_addr_i = 30'h80;
        n = 0;
        while (gnt_log.size() < 10 && n < 400) begin tick(); n++; end
        exp_seq = "RRRRWRRRRW";
        check("starve_grants", gnt_log.size(), 10);
        for (int i = 0; i < gnt_log.size() && i < 10; i++)
            check($sformatf("starve_gnt%0d", i), gnt_log[i], exp_seq[i]);

        // command FIFO full for 10 cycles in ST_RD_CMD
        do_reset();
        mig_ready_i = 1; rd_req_i = 1; rd_addr_i = 30'h500; cmd_full_on_gnt = 10;
        n = 0;
        while (rdv_log.size() < 1 && n < 100) begin tick(); n++; end
        check("cmdbp_count", cmd_log.size(), 1);
        if (cmd_log.size() > 0 && gnt_cyc.size() > 0)
            check("cmdbp_cycle", cmd_log[0].cyc - gnt_cyc[0], 11);

        // calibration gate
        do_reset();
        rd_req_i = 1; wr_req_i = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("cal_busy%0d", i), s_busy, 0);
        end
        check("cal_no_grant", gnt_log.size(), 0);
        mig_ready_i = 1;
        rc = cyc;
        tick();
        check("cal_grant_count", gnt_log.size(), 1);
        if (gnt_log.size() > 0) begin
            check("cal_grant_dir", gnt_log[0], "R");
            check("cal_grant_cycle", gnt_cyc[0], rc);
        end

        // reset during the third beat of a write fill
        do_reset();
        mig_ready_i = 1; wr_req_i = 1; wr_addr_i = 30'h600; wr_bl_i = 6'd7;
        n = 0;
        while (push_log.size() < 2 && n < 50) begin tick(); n++; end
        check("rstmid_reached", push_log.size(), 2);
        rst = 1; wr_req_i = 0;
        tick();
        rst = 0;
        @(negedge clk);
        check("rstmid_pop", wr_pop_o, 0);
        check("rstmid_wr_en", mig_wr_en, 0);
        check("rstmid_busy", busy_o, 0);
        @(posedge clk);
        #1;

        // randomized traffic with random backpressure against the reference model
        do_reset();
        rand_on = 1; mig_ready_i = 1; rd_dly = 0; wr_dly = 0;
        n = 0;
        while (n_grants < 60 && n < 15000) begin tick(); n++; end
        rand_stop = 1;
        while ((rd_req_i || wr_req_i || m_busy || exp_rd.size() > 0) && n < 18000) begin tick(); n++; end
        check("rand_grants", n_grants >= 60, 1);
        check("rand_rd_left", exp_rd.size(), 0);
        check("rand_wr_left", exp_wr.size(), 0);
        check("rand_idle_end", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
